// File: rtl/rv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the RV32I multi-cycle control slice:
//   - base opcode constants (instr[6:0])
//   - FSM state encoding (IDLE=0 .. TRAP=6, also visible on the debug port)
//   - pc_sel / wb_sel mux encodings
//   - instruction class indices for the one-hot class vector
//   - registered control-word struct and small select helpers
// -----------------------------------------------------------------------------
package rv_ctrl_pkg;

   // Base opcodes
   localparam logic [6:0] opc_op     = 7'b0110011;
   localparam logic [6:0] opc_op_imm = 7'b0010011;
   localparam logic [6:0] opc_load   = 7'b0000011;
   localparam logic [6:0] opc_store  = 7'b0100011;
   localparam logic [6:0] opc_branch = 7'b1100011;
   localparam logic [6:0] opc_lui    = 7'b0110111;
   localparam logic [6:0] opc_auipc  = 7'b0010111;
   localparam logic [6:0] opc_jal    = 7'b1101111;
   localparam logic [6:0] opc_jalr   = 7'b1100111;
   localparam logic [6:0] opc_system = 7'b1110011;

   // FSM states
   typedef enum logic [2:0] {
      st_idle   = 3'd0,
      st_fetch  = 3'd1,
      st_decode = 3'd2,
      st_exec   = 3'd3,
      st_mem    = 3'd4,
      st_wb     = 3'd5,
      st_trap   = 3'd6
   } state_t;

   // Next-PC select
   localparam logic [1:0] pcsel_pc4 = 2'b00;
   localparam logic [1:0] pcsel_imm = 2'b01;
   localparam logic [1:0] pcsel_reg = 2'b10;

   // Register write-back select
   localparam logic [1:0] wbsel_alu  = 2'b00;
   localparam logic [1:0] wbsel_load = 2'b01;
   localparam logic [1:0] wbsel_pc4  = 2'b10;
   localparam logic [1:0] wbsel_imm  = 2'b11;

   // One-hot class vector bit positions
   localparam int cls_op     = 0;
   localparam int cls_op_imm = 1;
   localparam int cls_load   = 2;
   localparam int cls_store  = 3;
   localparam int cls_branch = 4;
   localparam int cls_lui    = 5;
   localparam int cls_auipc  = 6;
   localparam int cls_jal    = 7;
   localparam int cls_jalr   = 8;
   localparam int cls_sys    = 9;
   localparam int cls_w      = 10;

   // Registered control word. store_ack_pc and br_exec are qualifiers that
   // are combined with dmem_ack / br_cond at the output.
   typedef struct packed {
      logic       imem_req;
      logic       dmem_req;
      logic       dmem_we;
      logic       pc_we;
      logic       store_ack_pc;
      logic       br_exec;
      logic [1:0] pc_sel;
      logic       alu_a_sel;
      logic       alu_b_sel;
      logic       rf_we;
      logic [1:0] wb_sel;
      logic       halt;
      logic       illegal;
   } ctrl_t;

   // Write-back source for an instruction class
   function automatic logic [1:0] wb_sel_of(input logic [cls_w-1:0] cls);
      logic [1:0] sel;
      if (cls[cls_lui]) begin
         sel = wbsel_imm;
      end else if (cls[cls_jal] | cls[cls_jalr]) begin
         sel = wbsel_pc4;
      end else if (cls[cls_load]) begin
         sel = wbsel_load;
      end else if (cls[cls_op] | cls[cls_op_imm] | cls[cls_auipc]) begin
         sel = wbsel_alu;
      end else begin
         sel = wbsel_alu;
      end
      return sel;
   endfunction

   // Next-PC source used in the write-back phase
   function automatic logic [1:0] wb_pc_sel_of(input logic [cls_w-1:0] cls);
      logic [1:0] sel;
      if (cls[cls_jal]) begin
         sel = pcsel_imm;
      end else if (cls[cls_jalr]) begin
         sel = pcsel_reg;
      end else begin
         sel = pcsel_pc4;
      end
      return sel;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_dec
// Combinational opcode-to-class decoder.
//   opcode  in  7         instr[6:0]
//   cls     out cls_w     one-hot instruction class (all zero when illegal)
//   illegal out 1         opcode is not a supported RV32I base opcode
// -----------------------------------------------------------------------------
module multicycle_ctrl_dec
   import rv_ctrl_pkg::*;
(
   input  logic [6:0]       opcode,
   output logic [cls_w-1:0] cls,
   output logic             illegal
);

   // Map opcode to its class bit; anything unknown flags illegal
   always_comb begin
      cls     = {cls_w{1'b0}};
      illegal = 1'b0;
      case (opcode)
         opc_op:     cls[cls_op]     = 1'b1;
         opc_op_imm: cls[cls_op_imm] = 1'b1;
         opc_load:   cls[cls_load]   = 1'b1;
         opc_store:  cls[cls_store]  = 1'b1;
         opc_branch: cls[cls_branch] = 1'b1;
         opc_lui:    cls[cls_lui]    = 1'b1;
         opc_auipc:  cls[cls_auipc]  = 1'b1;
         opc_jal:    cls[cls_jal]    = 1'b1;
         opc_jalr:   cls[cls_jalr]   = 1'b1;
         opc_system: cls[cls_sys]    = 1'b1;
         default:    illegal         = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Parks in TRAP on ECALL/EBREAK (SYSTEM) or an unknown opcode until reset.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/ack/rdata         instruction fetch handshake and data
//   instr                      instruction register
//   dmem_req/we/ack            data access handshake (we=1 store)
//   br_cond                    branch comparison result from the ALU
//   pc_we, pc_sel              PC update strobe and next-PC select
//   alu_a_sel, alu_b_sel       ALU operand selects
//   rf_we, wb_sel              register write strobe and source select
//   halt, illegal              trap reached / trap cause is unknown opcode
//   state                      current FSM state (debug)
//   cycle_cnt, instret_cnt     only with MULTICYCLE_CTRL_PERF_EN defined
//
// Outputs are decoded from the next state and the instruction register and
// then registered, so they reset asynchronously with the FSM. Two outputs
// also qualify a registered flag with an input in the same cycle: the branch
// target select (br_cond, valid only during EXEC) and the store completion
// PC strobe (dmem_ack, ends the MEM phase).
// -----------------------------------------------------------------------------
module multicycle_ctrl
   import rv_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   input  logic        br_cond,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        halt,
   output logic        illegal,
   output logic [2:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
`endif
);

   state_t           state_r;
   state_t           state_nx_s;
   logic [31:0]      instr_r;
   ctrl_t            ctrl_r;
   ctrl_t            ctrl_nx_s;
   logic [cls_w-1:0] cls_s;
   logic             dec_illegal_s;

   multicycle_ctrl_dec u_dec (
      .opcode  (instr_r[6:0]),
      .cls     (cls_s),
      .illegal (dec_illegal_s)
   );

   // Sequencing rules. Acks are only looked at in the state that raises the
   // matching request, so stray acks are ignored by construction.
   function automatic state_t next_state(
      input state_t           st,
      input logic [cls_w-1:0] cls,
      input logic             ill,
      input logic             iack,
      input logic             dack
   );
      state_t nx;
      nx = st;
      case (st)
         st_idle: nx = st_fetch;
         st_fetch: begin
            if (iack) nx = st_decode;
            else      nx = st_fetch;
         end
         st_decode: begin
            if (ill | cls[cls_sys]) nx = st_trap;
            else                    nx = st_exec;
         end
         st_exec: begin
            if (cls[cls_branch])                     nx = st_fetch;
            else if (cls[cls_load] | cls[cls_store]) nx = st_mem;
            else                                     nx = st_wb;
         end
         st_mem: begin
            if (!dack)               nx = st_mem;
            else if (cls[cls_load])  nx = st_wb;
            else                     nx = st_fetch;
         end
         st_wb:   nx = st_fetch;
         st_trap: nx = st_trap;
         default: nx = st_trap;
      endcase
      return nx;
   endfunction

   // Moore control word for a state and instruction class
   function automatic ctrl_t ctrl_of(
      input state_t           st,
      input logic [cls_w-1:0] cls,
      input logic             ill
   );
      ctrl_t c;
      c = '0;
      case (st)
         st_fetch: c.imem_req = 1'b1;
         st_exec: begin
            c.alu_a_sel = cls[cls_auipc];
            c.alu_b_sel = ~(cls[cls_op] | cls[cls_branch]);
            c.pc_we     = cls[cls_branch];
            c.br_exec   = cls[cls_branch];
         end
         st_mem: begin
            c.dmem_req     = 1'b1;
            c.dmem_we      = cls[cls_store];
            c.store_ack_pc = cls[cls_store];
         end
         st_wb: begin
            c.rf_we  = 1'b1;
            c.pc_we  = 1'b1;
            c.wb_sel = wb_sel_of(cls);
            c.pc_sel = wb_pc_sel_of(cls);
         end
         st_trap: begin
            c.halt    = 1'b1;
            c.illegal = ill;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   assign state_nx_s = next_state(state_r, cls_s, dec_illegal_s, imem_ack, dmem_ack);
   assign ctrl_nx_s  = ctrl_of(state_nx_s, cls_s, dec_illegal_s);

   // FSM state, instruction register and registered control outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= st_idle;
         instr_r <= 32'h0000_0000;
         ctrl_r  <= '0;
      end else begin
         state_r <= state_nx_s;
         ctrl_r  <= ctrl_nx_s;
         if ((state_r == st_fetch) && imem_ack) begin
            instr_r <= imem_rdata;
         end else begin
            instr_r <= instr_r;
         end
      end
   end

   assign state     = state_r;
   assign instr     = instr_r;
   assign imem_req  = ctrl_r.imem_req;
   assign dmem_req  = ctrl_r.dmem_req;
   assign dmem_we   = ctrl_r.dmem_we;
   assign alu_a_sel = ctrl_r.alu_a_sel;
   assign alu_b_sel = ctrl_r.alu_b_sel;
   assign rf_we     = ctrl_r.rf_we;
   assign wb_sel    = ctrl_r.wb_sel;
   assign halt      = ctrl_r.halt;
   assign illegal   = ctrl_r.illegal;
   // Store retires on the cycle its data access completes
   assign pc_we     = ctrl_r.pc_we | (ctrl_r.store_ack_pc & dmem_ack);
   // Branch target only when the ALU reports the condition taken
   assign pc_sel    = (ctrl_r.br_exec & br_cond) ? pcsel_imm : ctrl_r.pc_sel;

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] cycle_cnt_r;
   logic [31:0] instret_cnt_r;

   // Active-cycle and retired-instruction counters, wrapping modulo 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_r   <= 32'd0;
         instret_cnt_r <= 32'd0;
      end else begin
         if ((state_r != st_idle) && (state_r != st_trap)) begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
         end else begin
            cycle_cnt_r <= cycle_cnt_r;
         end
         if (pc_we) begin
            instret_cnt_r <= instret_cnt_r + 32'd1;
         end else begin
            instret_cnt_r <= instret_cnt_r;
         end
      end
   end

   assign cycle_cnt   = cycle_cnt_r;
   assign instret_cnt = instret_cnt_r;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl: a hand-written vector table, a
// phase-list reference model driven with random instructions and wait
// states, and directed trap / reset-abort sequences.
// Output vector layout used for all compares:
//   {state[2:0], imem_req, dmem_req, dmem_we, pc_we, pc_sel[1:0],
//    alu_a_sel, alu_b_sel, rf_we, wb_sel[1:0], halt, illegal}
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ack;
   logic [31:0] imem_rdata, instr;
   logic        dmem_req, dmem_we, dmem_ack, br_cond;
   logic        pc_we, alu_a_sel, alu_b_sel, rf_we, halt, illegal;
   logic [1:0]  pc_sel, wb_sel;
   logic [2:0]  state;
`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .br_cond(br_cond), .pc_we(pc_we), .pc_sel(pc_sel),
      .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
      .wb_sel(wb_sel), .halt(halt), .illegal(illegal), .state(state)
`ifdef MULTICYCLE_CTRL_PERF_EN
      , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [15:0] act_s;
   assign act_s = {state, imem_req, dmem_req, dmem_we, pc_we, pc_sel,
                   alu_a_sel, alu_b_sel, rf_we, wb_sel, halt, illegal};

   typedef struct packed {
      logic        ia;
      logic [31:0] rd;
      logic        da;
      logic        br;
      logic [15:0] e;
   } vec_t;

   vec_t tbl[$];
   vec_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   localparam logic [31:0] ADDI  = 32'h0050_0093;
   localparam logic [31:0] LW    = 32'h0000_A103;
   localparam logic [31:0] BEQ   = 32'h0000_0463;
   localparam logic [31:0] JALR  = 32'h0001_00E7;
   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam logic [31:0] ILL   = 32'h0000_007F;
   localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

   function automatic logic [15:0] mk(input int st, input int ir, input int dr,
      input int dw, input int pw, input int ps, input int aa, input int ab,
      input int rw, input int ws, input int h, input int il);
      logic [15:0] e;
      e = {st[2:0], ir[0], dr[0], dw[0], pw[0], ps[1:0], aa[0], ab[0], rw[0],
           ws[1:0], h[0], il[0]};
      return e;
   endfunction

   function automatic vec_t row(input int ia, input logic [31:0] rd,
      input int da, input int br, input logic [15:0] e);
      vec_t v;
      v.ia = ia[0]; v.rd = rd; v.da = da[0]; v.br = br[0]; v.e = e;
      return v;
   endfunction

   function automatic int rb();
      return int'($urandom_range(0, 1));
   endfunction

   task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, a, e, $time);
      end
   endtask

   // One clock cycle: drive this cycle's inputs after the edge, then compare
   task automatic cyc(input vec_t v, input string nm);
      @(posedge clk); #1;
      imem_ack = v.ia; imem_rdata = v.rd; dmem_ack = v.da; br_cond = v.br;
      #1;
      check(nm, {16'h0000, act_s}, {16'h0000, v.e});
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; br_cond = 1'b0;
      #1;
      check("reset_outputs", {16'h0000, act_s}, 32'h0000_0000);
      check("reset_instr", instr, 32'h0000_0000);
`ifdef MULTICYCLE_CTRL_PERF_EN
      check("reset_cycle_cnt", cycle_cnt, 32'h0000_0000);
      check("reset_instret_cnt", instret_cnt, 32'h0000_0000);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("idle_after_reset", {16'h0000, act_s}, 32'h0000_0000);
   endtask

   // Reference model: expected per-cycle outputs of one instruction built
   // from its phase list (fetch waits, decode, exec, mem waits, write-back)
   task automatic gen(input logic [31:0] ins, input int iw, input int dw, input int br);
      logic [6:0] opc;
      int is_op, is_opi, is_ld, is_st, is_br, is_lui, is_aui, is_jal, is_jalr;
      int ws, ps;
      opc     = ins[6:0];
      is_op   = (opc == 7'b0110011) ? 1 : 0;
      is_opi  = (opc == 7'b0010011) ? 1 : 0;
      is_ld   = (opc == 7'b0000011) ? 1 : 0;
      is_st   = (opc == 7'b0100011) ? 1 : 0;
      is_br   = (opc == 7'b1100011) ? 1 : 0;
      is_lui  = (opc == 7'b0110111) ? 1 : 0;
      is_aui  = (opc == 7'b0010111) ? 1 : 0;
      is_jal  = (opc == 7'b1101111) ? 1 : 0;
      is_jalr = (opc == 7'b1100111) ? 1 : 0;
      for (int k = 0; k <= iw; k++)
         q.push_back(row((k == iw) ? 1 : 0, (k == iw) ? ins : $urandom(), rb(), rb(),
                         mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      q.push_back(row(rb(), $urandom(), rb(), rb(), mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      q.push_back(row(rb(), $urandom(), rb(), br,
                      mk(3, 0, 0, 0, is_br, (is_br == 1 && br == 1) ? 1 : 0, is_aui,
                         (is_op == 1 || is_br == 1) ? 0 : 1, 0, 0, 0, 0)));
      if (is_ld == 1 || is_st == 1)
         for (int k = 0; k <= dw; k++)
            q.push_back(row(rb(), $urandom(), (k == dw) ? 1 : 0, rb(),
                            mk(4, 0, 1, is_st, (is_st == 1 && k == dw) ? 1 : 0,
                               0, 0, 0, 0, 0, 0, 0)));
      if (is_br == 0 && is_st == 0) begin
         ws = (is_lui == 1) ? 3 : (is_jal == 1 || is_jalr == 1) ? 2 : (is_ld == 1) ? 1 : 0;
         ps = (is_jal == 1) ? 1 : (is_jalr == 1) ? 2 : 0;
         if (is_op + is_opi + is_aui + is_ld + is_lui + is_jal + is_jalr != 1)
            ws = -1;
         q.push_back(row(rb(), $urandom(), rb(), rb(),
                         mk(5, 0, 0, 0, 1, ps, 0, 0, 1, ws, 0, 0)));
      end
   endtask

   task automatic trap_seq(input logic [31:0] ins, input int il, input string nm);
      cyc(row(1, ins, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)), nm);
      cyc(row(0, JUNK, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)), nm);
      for (int k = 0; k < 6; k++)
         cyc(row(1, JUNK, 1, 1, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, il)), nm);
   endtask

   logic [6:0] opcs [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                           7'b1100111};

   initial begin
      logic [31:0] r;
      int pw_sum;
      rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; br_cond = 1'b0;
      imem_rdata = JUNK;

      // addi, 1 fetch wait; lw, 2 dmem waits; beq taken / not taken; jalr
      tbl.push_back(row(0, JUNK, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(1, ADDI, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 0, mk(5, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(1, LW,   0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 0, mk(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 0, mk(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 1, 0, mk(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 0, mk(5, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0)));
      tbl.push_back(row(1, BEQ,  0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 1, mk(3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(1, BEQ,  0, 1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 0, mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(1, JALR, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)));
      tbl.push_back(row(0, JUNK, 0, 0, mk(5, 0, 0, 0, 1, 2, 0, 0, 1, 2, 0, 0)));

      repeat (2) @(posedge clk);
      do_reset();

      pw_sum = 0;
      foreach (tbl[i]) begin
         cyc(tbl[i], "table");
         if (i == 5) check("addi_instr", instr, ADDI);
      end
`ifdef MULTICYCLE_CTRL_PERF_EN
      for (int i = 0; i < tbl.size() - 1; i++) pw_sum += int'(tbl[i].e[9]);
      check("table_cycle_cnt", cycle_cnt, 32'(tbl.size() - 1));
      check("table_instret_cnt", instret_cnt, 32'(pw_sum));
`endif

      // Random instructions and wait states against the phase model
      repeat (60) begin
         r = $urandom();
         gen({r[31:7], opcs[$urandom_range(0, 8)]}, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), rb());
         while (q.size() > 0) cyc(q.pop_front(), "random");
      end

      // Traps: SYSTEM (not illegal) and unknown opcode; no fetch afterwards
      trap_seq(ECALL, 0, "trap_ecall");
      do_reset();
      trap_seq(ILL, 1, "trap_illegal");
      check("trap_instr", instr, ILL);
      do_reset();

      // Reset during a MEM wait, then a late dmem_ack
      cyc(row(1, LW,   0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)), "abort_pre");
      cyc(row(0, JUNK, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)), "abort_pre");
      cyc(row(0, JUNK, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)), "abort_pre");
      cyc(row(0, JUNK, 0, 0, mk(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)), "abort_pre");
      cyc(row(0, JUNK, 0, 0, mk(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)), "abort_pre");
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_outputs", {16'h0000, act_s}, 32'h0000_0000);
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("abort_idle", {16'h0000, act_s}, 32'h0000_0000);
`ifdef MULTICYCLE_CTRL_PERF_EN
      check("abort_cycle_cnt", cycle_cnt, 32'h0000_0000);
      check("abort_instret_cnt", instret_cnt, 32'h0000_0000);
`endif
      cyc(row(0, JUNK, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)), "late_ack");
      cyc(row(1, ADDI, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)), "post_abort");
      cyc(row(0, JUNK, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)), "post_abort");
      cyc(row(0, JUNK, 1, 0, mk(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)), "post_abort");
      cyc(row(0, JUNK, 1, 0, mk(5, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0)), "post_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I core: fetches one instruction at a time over a req/ack instruction-memory port, latches it into the instruction register (which feeds immediate generation and register-file addressing), then steps through decode, execute, memory and write-back phases. It drives every datapath enable and mux select, and parks in a trap state on ECALL/EBREAK or an illegal opcode.

## Interface
- No parameters; widths fixed at RV32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- instr  out  32  instruction register
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_ack  in  1  data access complete
- br_cond  in  1  branch comparison result from ALU
- pc_we  out  1  PC update strobe
- pc_sel  out  2  00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1
- alu_a_sel  out  1  0 rs1, 1 pc
- alu_b_sel  out  1  0 rs2, 1 imm
- rf_we  out  1  register-file write strobe
- wb_sel  out  2  00 ALU, 01 load data, 10 pc+4, 11 imm
- halt  out  1  trap state reached
- illegal  out  1  trap cause is an unknown opcode
- state  out  3  current FSM state, for debug

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE is the reset state. It always moves to FETCH on the next cycle.
- FETCH:
  - imem_req is held high until imem_ack is sampled high.
  - On ack: instr <= imem_rdata, then go to DECODE.
- DECODE: one cycle for register read and immediate settle. Transitions by instr[6:0]:
  - 0110011 OP, 0010011 OP-IMM, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR go to EXEC.
  - 1110011 SYSTEM goes to TRAP with illegal=0.
  - Any other opcode goes to TRAP with illegal=1.
- EXEC:
  - alu_a_sel=1 for AUIPC; otherwise 0.
  - alu_b_sel=1 for every class except OP and BRANCH.
  - BRANCH: pc_we=1; pc_sel=01 if br_cond, else 00; then go to FETCH.
  - LOAD and STORE go to MEM. All other classes go to WB.
- MEM:
  - dmem_req is held high, with dmem_we=1 for STORE.
  - Stay in MEM until dmem_ack. Then LOAD goes to WB; STORE asserts pc_we with pc_sel=00 and goes to FETCH.
- WB: rf_we=1 and pc_we=1, then go to FETCH.
  - wb_sel: OP/OP-IMM/AUIPC 00, LOAD 01, JAL/JALR 10, LUI 11.
  - pc_sel: JAL 01, JALR 10, all others 00.
- TRAP: halt=1 and every strobe is 0. TRAP is exited only by reset.
- Acks that arrive while the matching req is low are ignored.
- Signals that are undefined in a given state read 0.

## Timing
- All outputs are Moore-decoded from state and instr.
- Reset values:
  - state=IDLE and instr=0.
  - All strobes (pc_we, rf_we, imem_req, dmem_req, dmem_we) are 0.
  - All selects are 0, halt=0, illegal=0.
- Asserting rst_n low mid-instruction aborts immediately.
  - Requests drop in the same cycle, with no partial write.
  - Any ack arriving after the abort is ignored.
- Fetch latency: instr is valid on the edge where imem_ack=1 is sampled. Zero-wait-state ack gives a 1-cycle FETCH.
- Instruction cost with zero-wait memory:
  - BRANCH: 3 cycles.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle on imem or dmem adds one.
- pc_we and rf_we are exactly one-cycle pulses per instruction.

## Configuration
- The macro MULTICYCLE_CTRL_PERF_EN is the only option.
- Defined: two extra 32-bit outputs are added.
  - cycle_cnt increments every cycle outside IDLE and TRAP.
  - instret_cnt increments on each pc_we.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: these ports and the counter logic are absent, and all other behaviour is identical.

## Structure
- Shared package rv_ctrl_pkg holds:
  - opcode constants;
  - the state encoding (IDLE=0 through TRAP=6);
  - the pc_sel and wb_sel encodings.
- One sub-module, multicycle_ctrl_dec: a combinational opcode-to-class decoder that outputs a one-hot class vector plus an illegal flag.

## Test plan
- addi x1,x0,5 (0x00500093), imem_ack 2 cycles after req -> FETCH lasts 2 cycles; DECODE, EXEC, then WB with rf_we=1, wb_sel=00, pc_we=1, pc_sel=00; back in FETCH after 5 cycles.
- lw x2,0(x1) (0x0000A103), dmem_ack after 3 MEM cycles -> dmem_we=0 throughout; WB with wb_sel=01; 7 cycles total.
- beq x0,x0,8 (0x00000463), br_cond=1 -> pc_we with pc_sel=01 in EXEC and no rf_we; with br_cond=0, pc_sel=00.
- jalr x1,0(x2) (0x000100E7) -> WB with rf_we=1, wb_sel=10, pc_sel=10.
- ecall (0x00000073) -> TRAP, halt=1, illegal=0. Opcode 0x7F -> halt=1, illegal=1. No further imem_req until rst_n pulses low.
- rst_n low during a MEM wait -> dmem_req drops asynchronously. After release: IDLE, then FETCH; a late dmem_ack is ignored. With PERF_EN defined, both counters read 0.
